message_serializer: RTL and testbench



---
 rtl/message_serializer.sv | 113 +++++++++++
 tb/tb_message_serializer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/message_serializer.sv
// Latches an MSG_W-bit message on an accepted send and shifts it out on SerOut, holding each bit BIT_CYCLES clocks.
// Optional macro PARITY_BIT_EN appends one even-parity bit (XOR of the captured message) to every frame.
module message_serializer #(
    parameter int MSG_W      = 5,
    parameter int BIT_CYCLES = 1024,
    parameter int MSB_FIRST  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             send,
    input  logic [MSG_W-1:0] Msg,
    output logic             ready,
    output logic             SerOut,
    output logic             valid,
    output logic             done
);

`ifdef PARITY_BIT_EN
    localparam int FRAME_BITS = MSG_W + 1;
`else
    localparam int FRAME_BITS = MSG_W;
`endif
    localparam int HW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [MSG_W-1:0] shift_q, shift_n;
    logic [HW-1:0]    hold_q, hold_n;
    logic [BW-1:0]    bit_q, bit_n;
    logic             last_clk;
    logic             head_n;
    logic             ser_n, valid_n, done_n;
`ifdef PARITY_BIT_EN
    logic             par_q, par_n;
`endif

    always_comb begin
        state_n = state;
        shift_n = shift_q;
        hold_n  = hold_q;
        bit_n   = bit_q;
`ifdef PARITY_BIT_EN
        par_n   = par_q;
`endif
        last_clk = (state == SHIFT) && (hold_q == HOLD_LAST) && (bit_q == BIT_LAST);
        ready    = (state == IDLE) || last_clk;

        if (ready && send) begin
            state_n = SHIFT;
            shift_n = Msg;
            hold_n  = '0;
            bit_n   = '0;
`ifdef PARITY_BIT_EN
            par_n   = ^Msg;
`endif
        end else if (last_clk) begin
            state_n = IDLE;
            shift_n = '0;
            hold_n  = '0;
            bit_n   = '0;
        end else if (state == SHIFT) begin
            if (hold_q == HOLD_LAST) begin
                hold_n  = '0;
                bit_n   = bit_q + BW'(1);
                shift_n = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
            end else begin
                hold_n = hold_q + HW'(1);
            end
        end

        // Outputs are computed from next-state values so they can be registered without a cycle of lag.
        head_n = (MSB_FIRST != 0) ? shift_n[MSG_W-1] : shift_n[0];
`ifdef PARITY_BIT_EN
        if (bit_n == BW'(MSG_W)) begin
            head_n = par_n;
        end
`endif
        valid_n = (state_n == SHIFT);
        ser_n   = valid_n & head_n;
        done_n  = valid_n && (hold_n == HOLD_LAST) && (bit_n == BIT_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shift_q <= '0;
            hold_q  <= '0;
            bit_q   <= '0;
            SerOut  <= 1'b0;
            valid   <= 1'b0;
            done    <= 1'b0;
`ifdef PARITY_BIT_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            shift_q <= shift_n;
            hold_q  <= hold_n;
            bit_q   <= bit_n;
            SerOut  <= ser_n;
            valid   <= valid_n;
            done    <= done_n;
`ifdef PARITY_BIT_EN
            par_q   <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_message_serializer.sv
// Bench for message_serializer: MSB-first and LSB-first instances share stimulus; a per-cycle
// expected queue of {valid, SerOut, done} is filled on every accepted send and drained each cycle.
module tb_message_serializer;

    localparam int MSG_W = 5;
    localparam int BC    = 4;
`ifdef PARITY_BIT_EN
    localparam int FB = MSG_W + 1;
`else
    localparam int FB = MSG_W;
`endif

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic             send  = 1'b0;
    logic [MSG_W-1:0] msg   = '0;
    logic             ready_m, ser_m, valid_m, done_m;
    logic             ready_l, ser_l, valid_l, done_l;

    logic [2:0] exp_m[$];
    logic [2:0] exp_l[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    message_serializer #(.MSG_W(MSG_W), .BIT_CYCLES(BC), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .reset(reset), .send(send), .Msg(msg),
        .ready(ready_m), .SerOut(ser_m), .valid(valid_m), .done(done_m)
    );

    message_serializer #(.MSG_W(MSG_W), .BIT_CYCLES(BC), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset(reset), .send(send), .Msg(msg),
        .ready(ready_l), .SerOut(ser_l), .valid(valid_l), .done(done_l)
    );

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [MSG_W-1:0] m);
        logic bm, bl;
        for (int b = 0; b < FB; b++) begin
            if (b < MSG_W) begin
                bm = m[MSG_W-1-b];
                bl = m[b];
            end else begin
                bm = ^m;
                bl = ^m;
            end
            for (int c = 0; c < BC; c++) begin
                exp_m.push_back({1'b1, bm, (b == FB-1) && (c == BC-1)});
                exp_l.push_back({1'b1, bl, (b == FB-1) && (c == BC-1)});
            end
        end
    endtask

    // Called at a falling edge: checks the current cycle, then drives inputs for the next rising edge.
    task automatic tick(input logic s, input logic [MSG_W-1:0] m, input logic r);
        logic [2:0] em, el;
        logic       rdy;
        rdy = (exp_m.size() <= 1);
        em  = 3'b000;
        el  = 3'b000;
        if (exp_m.size() > 0) em = exp_m.pop_front();
        if (exp_l.size() > 0) el = exp_l.pop_front();
        chk("msb_out", {valid_m, ser_m, done_m}, em);
        chk("lsb_out", {valid_l, ser_l, done_l}, el);
        chk("msb_ready", {2'b00, ready_m}, {2'b00, rdy});
        chk("lsb_ready", {2'b00, ready_l}, {2'b00, rdy});
        reset = r;
        send  = s;
        msg   = m;
        if (r) begin
            exp_m.delete();
            exp_l.delete();
        end else if (s && rdy) begin
            push_frame(m);
        end
        @(negedge clk);
    endtask

    function automatic logic [MSG_W-1:0] rnd_msg();
        return MSG_W'($urandom());
    endfunction

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state, then idle.
        repeat (3) tick(1'b0, '0, 1'b0);

        // Single frame 10110; Msg wiggles after capture.
        tick(1'b1, 5'b10110, 1'b0);
        repeat (FB*BC + 2) tick(1'b0, rnd_msg(), 1'b0);

        // Back-to-back frames with send held high, new Msg on the done cycle.
        tick(1'b1, 5'b11111, 1'b0);
        repeat (FB*BC - 1) tick(1'b1, 5'b11111, 1'b0);
        tick(1'b1, 5'b00001, 1'b0);
        repeat (FB*BC - 1) tick(1'b0, rnd_msg(), 1'b0);
        repeat (3) tick(1'b0, '0, 1'b0);

        // send during a frame is ignored.
        tick(1'b1, 5'b10110, 1'b0);
        repeat (6) tick(1'b0, rnd_msg(), 1'b0);
        tick(1'b1, 5'b01001, 1'b0);
        repeat (FB*BC + 2) tick(1'b0, rnd_msg(), 1'b0);

        // Reset mid-frame, then a clean frame.
        tick(1'b1, 5'b01101, 1'b0);
        repeat (9) tick(1'b0, rnd_msg(), 1'b0);
        tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b0);
        tick(1'b1, 5'b11001, 1'b0);
        repeat (FB*BC + 2) tick(1'b0, rnd_msg(), 1'b0);

        // Random traffic, including sends that land on the done cycle.
        repeat (6) begin
            tick(1'b1, rnd_msg(), 1'b0);
            repeat ($urandom_range(FB*BC - 1, FB*BC + 3)) tick(1'($urandom_range(0, 1)), rnd_msg(), 1'b0);
        end
        repeat (2*FB*BC + 2) tick(1'b0, rnd_msg(), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
